// File: rtl/bf_uart_io.sv
// ---------------------------------------------------------------------------
// bf_uart_io
//
// CPU I/O-port peripheral. Serves the ',' (read) and '.' (write) instructions
// over an 8N1 UART. Writes are serialized onto uart_tx; bytes received on
// uart_rx are buffered in a small FIFO and handed back to reads.
//
// Parameters
//   clk_div     clocks per UART bit (legal 4..65535)
//   rx_fifo_aw  RX FIFO address width, depth = 2**rx_fifo_aw (must be >= 1)
//
// Ports
//   clk           system clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   io_req        CPU request level, held until io_ack is seen
//   io_dir        0 = read, 1 = write
//   io_wdata      byte to transmit (valid with io_req & io_dir)
//   io_ack        transaction complete, held until io_req falls
//   io_rdata      received byte, stable while io_ack = 1
//   uart_tx       serial out, idle high
//   uart_rx       serial in, asynchronous, idle high
//   tx_busy       TX shifter active
//   rx_overrun    sticky: received byte dropped because the FIFO was full
//   rx_frame_err  sticky: a stop bit was sampled low
// ---------------------------------------------------------------------------
module bf_uart_io #(
   parameter logic [15:0] clk_div    = 16'd434,
   parameter logic [7:0]  rx_fifo_aw = 8'd2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       io_req,
   input  logic       io_dir,
   input  logic [7:0] io_wdata,
   output logic       io_ack,
   output logic [7:0] io_rdata,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       tx_busy,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int AW    = int'(rx_fifo_aw);
   localparam int DEPTH = 2 ** AW;

   localparam logic [15:0] c_bitLast  = clk_div - 16'd1;
   localparam logic [15:0] c_halfLast = (clk_div >> 1) - 16'd1;
   localparam logic [AW:0] c_ptrOne   = 1;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_WR_WAIT,
      BUS_RD_WAIT,
      BUS_ACK
   } busState_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rxState_t;

   busState_t   r_busState;
   busState_t   w_busNext;
   logic        r_ack;
   logic [7:0]  r_rdata;
   logic        w_txLoad;
   logic        w_pop;

   logic        r_txBusy;
   logic [9:0]  r_txShift;
   logic [15:0] r_txCnt;
   logic [3:0]  r_txBitIdx;
   logic        w_txLastCycle;
   logic        w_txReady;

   logic        r_rxSync1;
   logic        r_rxSync2;
   logic        r_rxPrev;
   rxState_t    r_rxState;
   rxState_t    w_rxNext;
   logic [15:0] r_rxCnt;
   logic [2:0]  r_rxBitIdx;
   logic [7:0]  r_rxShift;
   logic        w_rxTick;
   logic        w_rxShiftEn;
   logic        w_rxPush;
   logic        w_rxErr;
   logic        r_rxOverrun;
   logic        r_rxFrameErr;

   logic [7:0]  r_fifoMem [DEPTH];
   logic [AW:0] r_wrPtr;
   logic [AW:0] r_rdPtr;
   logic        w_fifoEmpty;
   logic        w_fifoFull;
   logic        w_fifoWr;

   assign io_ack       = r_ack;
   assign io_rdata     = r_rdata;
   assign uart_tx      = r_txShift[0];
   assign tx_busy      = r_txBusy;
   assign rx_overrun   = r_rxOverrun;
   assign rx_frame_err = r_rxFrameErr;

   // The transmitter counts as ready during the final stop-bit cycle so that a
   // waiting write can load on that edge and its start bit follows with no gap.
   assign w_txLastCycle = r_txBusy && (r_txCnt == 16'd0) && (r_txBitIdx == 4'd9);
   assign w_txReady     = !r_txBusy || w_txLastCycle;

   assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
   assign w_fifoFull  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_fifoWr    = w_rxPush && (!w_fifoFull || w_pop);

   // Bus handshake next-state logic. Loads and pops only ever happen on the
   // transition into ACK, so each transaction moves exactly one byte.
   always_comb begin
      w_busNext = r_busState;
      w_txLoad  = 1'b0;
      w_pop     = 1'b0;
      case (r_busState)
         BUS_IDLE: begin
            if (io_req) begin
               if (io_dir) begin
                  if (w_txReady) begin
                     w_txLoad  = 1'b1;
                     w_busNext = BUS_ACK;
                  end else begin
                     w_busNext = BUS_WR_WAIT;
                  end
               end else begin
                  if (!w_fifoEmpty) begin
                     w_pop     = 1'b1;
                     w_busNext = BUS_ACK;
                  end else begin
                     w_busNext = BUS_RD_WAIT;
                  end
               end
            end
         end
         BUS_WR_WAIT: begin
            if (!io_req) begin
               w_busNext = BUS_IDLE;
            end else if (w_txReady) begin
               w_txLoad  = 1'b1;
               w_busNext = BUS_ACK;
            end
         end
         BUS_RD_WAIT: begin
            if (!io_req) begin
               w_busNext = BUS_IDLE;
            end else if (!w_fifoEmpty) begin
               w_pop     = 1'b1;
               w_busNext = BUS_ACK;
            end
         end
         BUS_ACK: begin
            if (!io_req) begin
               w_busNext = BUS_IDLE;
            end
         end
         default: begin
            w_busNext = BUS_IDLE;
         end
      endcase
   end

   // Bus state register. io_ack is a registered copy of the ACK state so it
   // rises one edge after the transaction completes and falls one edge after
   // the dropped request has been sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busState <= BUS_IDLE;
         r_ack      <= 1'b0;
         r_rdata    <= 8'h00;
      end else begin
         r_busState <= w_busNext;
         r_ack      <= (r_busState == BUS_ACK);
         if (w_pop) begin
            r_rdata <= r_fifoMem[r_rdPtr[AW-1:0]];
         end
      end
   end

   // TX shifter: start, 8 data bits LSB first, stop. Ones are shifted in from
   // the top so the line rests high once the frame has drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txBusy   <= 1'b0;
         r_txShift  <= '1;
         r_txCnt    <= 16'd0;
         r_txBitIdx <= 4'd0;
      end else if (w_txLoad) begin
         r_txBusy   <= 1'b1;
         r_txShift  <= {1'b1, io_wdata, 1'b0};
         r_txCnt    <= c_bitLast;
         r_txBitIdx <= 4'd0;
      end else if (r_txBusy) begin
         if (r_txCnt == 16'd0) begin
            r_txShift <= {1'b1, r_txShift[9:1]};
            if (r_txBitIdx == 4'd9) begin
               r_txBusy <= 1'b0;
            end else begin
               r_txBitIdx <= r_txBitIdx + 4'd1;
               r_txCnt    <= c_bitLast;
            end
         end else begin
            r_txCnt <= r_txCnt - 16'd1;
         end
      end
   end

   // Two-flop synchronizer on the asynchronous RX line plus one more flop to
   // detect the falling edge of the start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxSync1 <= 1'b1;
         r_rxSync2 <= 1'b1;
         r_rxPrev  <= 1'b1;
      end else begin
         r_rxSync1 <= uart_rx;
         r_rxSync2 <= r_rxSync1;
         r_rxPrev  <= r_rxSync2;
      end
   end

   // RX next-state logic. The start bit is re-checked at its midpoint to reject
   // glitches; every later sample lands one bit period after the previous one.
   always_comb begin
      w_rxNext    = r_rxState;
      w_rxTick    = (r_rxCnt == 16'd0);
      w_rxShiftEn = 1'b0;
      w_rxPush    = 1'b0;
      w_rxErr     = 1'b0;
      case (r_rxState)
         RX_IDLE: begin
            if (r_rxPrev && !r_rxSync2) begin
               w_rxNext = RX_START;
            end
         end
         RX_START: begin
            if (w_rxTick) begin
               w_rxNext = r_rxSync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (w_rxTick) begin
               w_rxShiftEn = 1'b1;
               if (r_rxBitIdx == 3'd7) begin
                  w_rxNext = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (w_rxTick) begin
               if (r_rxSync2) begin
                  w_rxPush = 1'b1;
                  w_rxNext = RX_IDLE;
               end else begin
                  w_rxErr  = 1'b1;
                  w_rxNext = RX_WAIT_HIGH;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (r_rxSync2) begin
               w_rxNext = RX_IDLE;
            end
         end
         default: begin
            w_rxNext = RX_IDLE;
         end
      endcase
   end

   // RX state, bit timer, data shifter and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxState    <= RX_IDLE;
         r_rxCnt      <= 16'd0;
         r_rxBitIdx   <= 3'd0;
         r_rxShift    <= 8'h00;
         r_rxOverrun  <= 1'b0;
         r_rxFrameErr <= 1'b0;
      end else begin
         r_rxState <= w_rxNext;
         if (r_rxState == RX_IDLE && w_rxNext == RX_START) begin
            r_rxCnt <= c_halfLast;
         end else if ((r_rxState == RX_START || r_rxState == RX_DATA) && w_rxTick) begin
            r_rxCnt <= c_bitLast;
         end else if (!w_rxTick) begin
            r_rxCnt <= r_rxCnt - 16'd1;
         end
         if (r_rxState == RX_START) begin
            r_rxBitIdx <= 3'd0;
         end else if (w_rxShiftEn) begin
            r_rxBitIdx <= r_rxBitIdx + 3'd1;
         end
         if (w_rxShiftEn) begin
            r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
         end
         if (w_rxPush && w_fifoFull && !w_pop) begin
            r_rxOverrun <= 1'b1;
         end
         if (w_rxErr) begin
            r_rxFrameErr <= 1'b1;
         end
      end
   end

   // FIFO pointers carry one extra wrap bit so full and empty can be told apart.
   // A push into a full FIFO still succeeds when a pop frees the slot that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_fifoWr) begin
            r_wrPtr <= r_wrPtr + c_ptrOne;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + c_ptrOne;
         end
      end
   end

   // FIFO storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_fifoWr) begin
         r_fifoMem[r_wrPtr[AW-1:0]] <= r_rxShift;
      end
   end

endmodule

// File: tb/tb_bf_uart_io.sv
// ---------------------------------------------------------------------------
// tb_bf_uart_io
//
// Directed bench for bf_uart_io with clk_div = 8 and a 4-entry RX FIFO.
// A vector table covers plain writes and reads; hand-written sequences cover
// back-to-back writes, blocking reads, overrun, glitch rejection, framing
// errors and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_bf_uart_io;

   localparam int ClkDiv = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       io_req = 1'b0;
   logic       io_dir = 1'b0;
   logic [7:0] io_wdata = 8'h00;
   logic       uart_rx = 1'b1;
   logic       io_ack;
   logic [7:0] io_rdata;
   logic       uart_tx;
   logic       tx_busy;
   logic       rx_overrun;
   logic       rx_frame_err;

   bf_uart_io #(
      .clk_div    (16'd8),
      .rx_fifo_aw (8'd2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .io_req       (io_req),
      .io_dir       (io_dir),
      .io_wdata     (io_wdata),
      .io_ack       (io_ack),
      .io_rdata     (io_rdata),
      .uart_tx      (uart_tx),
      .uart_rx      (uart_rx),
      .tx_busy      (tx_busy),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         isWrite;
      logic [7:0] data;
      logic [9:0] expFrame;
      logic [7:0] expRdata;
   } vec_t;

   vec_t vecs[7];
   int   vecCount = 0;
   int   missCount = 0;
   int   lat;
   bit   acked;

   logic txBits[$];
   int   monCnt = 0;
   int   lastRun = 0;

   // Line monitor: samples uart_tx in the middle of every bit while tx_busy is
   // high and records how long each continuous busy stretch lasted.
   always @(negedge clk) begin
      if (tx_busy) begin
         if (monCnt % ClkDiv == ClkDiv / 2) begin
            txBits.push_back(uart_tx);
         end
         monCnt <= monCnt + 1;
      end else if (monCnt != 0) begin
         lastRun <= monCnt;
         monCnt  <= 0;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] frameAt(input int base);
      logic [9:0] f;
      f = '0;
      for (int i = 0; i < 10; i++) begin
         if (base + i < txBits.size()) begin
            f[i] = txBits[base + i];
         end
      end
      return f;
   endfunction

   // Raise a request and wait (bounded) for io_ack; lat counts edges.
   task automatic startXfer(input logic dir, input logic [7:0] data, input int maxCycles,
                            output int latOut, output bit ackedOut);
      io_dir   = dir;
      io_wdata = data;
      io_req   = 1'b1;
      latOut   = 0;
      ackedOut = 1'b0;
      for (int i = 0; i < maxCycles; i++) begin
         tick();
         latOut++;
         if (io_ack) begin
            ackedOut = 1'b1;
            break;
         end
      end
   endtask

   // Drop the request: ack stays up for the edge that samples the drop, then falls.
   task automatic endXfer();
      io_req = 1'b0;
      tick();
      checkOutput("ackHold", 16'(io_ack), 16'd1);
      tick();
      checkOutput("ackDrop", 16'(io_ack), 16'd0);
   endtask

   task automatic waitTxIdle();
      for (int i = 0; i < 400; i++) begin
         if (!tx_busy) break;
         tick();
      end
      checkOutput("txIdle", 16'(tx_busy), 16'd0);
      tick();
      tick();
   endtask

   task automatic sendRx(input logic [7:0] data, input logic stopBit);
      uart_rx = 1'b0;
      repeat (ClkDiv) tick();
      for (int b = 0; b < 8; b++) begin
         uart_rx = data[b];
         repeat (ClkDiv) tick();
      end
      uart_rx = stopBit;
      repeat (ClkDiv) tick();
      uart_rx = 1'b1;
      repeat (ClkDiv) tick();
   endtask

   task automatic expectReadBlocks(input string name);
      int  l;
      bit  a;
      startXfer(1'b0, 8'h00, 40, l, a);
      checkOutput(name, 16'(a), 16'd0);
      io_req = 1'b0;
      tick();
      tick();
      checkOutput({name, "Idle"}, 16'(io_ack), 16'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      int l;
      bit a;
      if (v.isWrite) begin
         txBits.delete();
         startXfer(1'b1, v.data, 400, l, a);
         checkOutput("wrAck", 16'(a), 16'd1);
         checkOutput("wrLatency", 16'(l), 16'd2);
         checkOutput("wrBusy", 16'(tx_busy), 16'd1);
         endXfer();
         waitTxIdle();
         checkOutput("txBitCount", 16'(txBits.size()), 16'd10);
         checkOutput("txFrame", 16'(frameAt(0)), 16'(v.expFrame));
         checkOutput("txBusyLen", 16'(lastRun), 16'd80);
      end else begin
         sendRx(v.data, 1'b1);
         startXfer(1'b0, 8'h00, 50, l, a);
         checkOutput("rdAck", 16'(a), 16'd1);
         checkOutput("rdLatency", 16'(l), 16'd2);
         checkOutput("rdData", 16'(io_rdata), 16'(v.expRdata));
         endXfer();
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 8'h41, 10'b1010000010, 8'h00};
      vecs[1] = '{1'b1, 8'h00, 10'b1000000000, 8'h00};
      vecs[2] = '{1'b1, 8'hFF, 10'b1111111110, 8'h00};
      vecs[3] = '{1'b1, 8'hA5, 10'b1101001010, 8'h00};
      vecs[4] = '{1'b0, 8'h00, 10'b0000000000, 8'h00};
      vecs[5] = '{1'b0, 8'hFF, 10'b0000000000, 8'hFF};
      vecs[6] = '{1'b0, 8'h5A, 10'b0000000000, 8'h5A};

      repeat (3) tick();
      checkOutput("rstAck", 16'(io_ack), 16'd0);
      checkOutput("rstRdata", 16'(io_rdata), 16'h00);
      checkOutput("rstTx", 16'(uart_tx), 16'd1);
      checkOutput("rstBusy", 16'(tx_busy), 16'd0);
      checkOutput("rstOverrun", 16'(rx_overrun), 16'd0);
      checkOutput("rstFrameErr", 16'(rx_frame_err), 16'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] back-to-back writes");
      txBits.delete();
      startXfer(1'b1, 8'h55, 400, lat, acked);
      checkOutput("b2bLat1", 16'(lat), 16'd2);
      endXfer();
      startXfer(1'b1, 8'hAA, 400, lat, acked);
      checkOutput("b2bAck2", 16'(acked), 16'd1);
      checkOutput("b2bLat2", 16'(lat), 16'd78);
      endXfer();
      waitTxIdle();
      checkOutput("b2bBusyLen", 16'(lastRun), 16'd160);
      checkOutput("b2bBitCount", 16'(txBits.size()), 16'd20);
      checkOutput("b2bFrame1", 16'(frameAt(0)), 16'(10'b1010101010));
      checkOutput("b2bFrame2", 16'(frameAt(10)), 16'(10'b1101010100));

      $display("[TB] read while FIFO empty");
      fork
         startXfer(1'b0, 8'h00, 300, lat, acked);
         begin
            repeat (5) tick();
            sendRx(8'h3C, 1'b1);
         end
      join
      checkOutput("rdWaitAck", 16'(acked), 16'd1);
      checkOutput("rdWaitHeld", 16'(lat > 60), 16'd1);
      checkOutput("rdWaitData", 16'(io_rdata), 16'h3C);
      endXfer();
      checkOutput("rdataKept", 16'(io_rdata), 16'h3C);

      $display("[TB] overrun");
      for (int k = 1; k <= 4; k++) begin
         sendRx(8'(k), 1'b1);
      end
      checkOutput("noOverrunAt4", 16'(rx_overrun), 16'd0);
      sendRx(8'h05, 1'b1);
      checkOutput("overrun", 16'(rx_overrun), 16'd1);
      checkOutput("noFrameErr", 16'(rx_frame_err), 16'd0);
      for (int k = 1; k <= 4; k++) begin
         startXfer(1'b0, 8'h00, 50, lat, acked);
         checkOutput("ovAck", 16'(acked), 16'd1);
         checkOutput("ovData", 16'(io_rdata), 16'(k));
         endXfer();
      end
      expectReadBlocks("ovEmptyBlocks");

      $display("[TB] glitch and framing error");
      uart_rx = 1'b0;
      repeat (3) tick();
      uart_rx = 1'b1;
      repeat (30) tick();
      checkOutput("glitchFrameErr", 16'(rx_frame_err), 16'd0);
      expectReadBlocks("glitchNoPush");
      sendRx(8'h77, 1'b0);
      repeat (10) tick();
      checkOutput("frameErr", 16'(rx_frame_err), 16'd1);
      expectReadBlocks("frameErrNoPush");
      sendRx(8'h99, 1'b1);
      startXfer(1'b0, 8'h00, 50, lat, acked);
      checkOutput("rearmAck", 16'(acked), 16'd1);
      checkOutput("rearmData", 16'(io_rdata), 16'h99);
      endXfer();
      checkOutput("frameErrSticky", 16'(rx_frame_err), 16'd1);
      checkOutput("overrunSticky", 16'(rx_overrun), 16'd1);

      $display("[TB] reset mid-frame and mid-ACK");
      io_dir   = 1'b1;
      io_wdata = 8'h00;
      io_req   = 1'b1;
      tick();
      tick();
      checkOutput("preRstAck", 16'(io_ack), 16'd1);
      repeat (20) tick();
      checkOutput("preRstBusy", 16'(tx_busy), 16'd1);
      checkOutput("preRstTx", 16'(uart_tx), 16'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstTx", 16'(uart_tx), 16'd1);
      checkOutput("midRstAck", 16'(io_ack), 16'd0);
      checkOutput("midRstBusy", 16'(tx_busy), 16'd0);
      checkOutput("midRstRdata", 16'(io_rdata), 16'h00);
      checkOutput("midRstFlags", 16'({rx_overrun, rx_frame_err}), 16'd0);
      io_req = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      applyStimulus(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
